// File: rtl/tholin_5401_nibble_responder.sv
// ----------------------------------------------------------------------------
// tholin_5401_nibble_responder
//
// External memory/IO responder for the 5401 CPU. The CPU drives a nibble-serial
// protocol on its 8-bit io_out bus. ALE cycles shift in an address, MSB nibble
// first. Once a full address has been loaded, each RD cycle returns one nibble
// on data_out and each WR cycle stores one nibble. Both advance the address
// pointer. Read data is registered and appears one cycle after RD is sampled.
//
// Ports:
//   CLK       in   clock, all state on rising edge
//   RST       in   asynchronous active-low reset
//   bus_in    in   [3:0] nib, [4] ale, [5] rd, [6] wr, [7] ignored
//   data_out  out  registered read data to the CPU data_in pins
//   addr      out  current address pointer (debug)
//   ready     out  high while a complete address is held
//   err       out  sticky protocol-error flag, cleared only by reset
// ----------------------------------------------------------------------------
module tholin_5401_nibble_responder #(
    parameter int MEM_DEPTH    = 256,
    parameter int ADDR_NIBBLES = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [7:0]                bus_in,
    output logic [3:0]                data_out,
    output logic [4*ADDR_NIBBLES-1:0] addr,
    output logic                      ready,
    output logic                      err
);

    localparam int AW = 4 * ADDR_NIBBLES;
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = $clog2(ADDR_NIBBLES + 1);

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(MEM_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(ADDR_NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_READY = 2'd2
    } state_t;

    logic [3:0] nib;
    logic       ale, rd, wr;
    logic       unused_bus7;

    assign nib         = bus_in[3:0];
    assign ale         = bus_in[4];
    assign rd          = bus_in[5];
    assign wr          = bus_in[6];
    assign unused_bus7 = bus_in[7];

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    dout_q;
    logic          err_q, err_d;

    logic [3:0]    mem [MEM_DEPTH];

    logic          in_range;
    logic          rd_hit;   // in-range read: load data_out from RAM
    logic          dout_f;   // out-of-range read or stray access: drive 4'hF
    logic          we;
    logic [IW-1:0] idx;

    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign idx      = addr_q[IW-1:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_hit  = 1'b0;
        dout_f  = 1'b0;
        we      = 1'b0;

        if (ale) begin
            // ALE overrides rd/wr. Surplus nibbles keep shifting, so the
            // last ADDR_NIBBLES nibbles form the address.
            state_d = S_ADDR;
            addr_d  = AW'({addr_q, nib});
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end else begin
            unique case (state_q)
                S_ADDR: begin
                    // ALE just dropped. rd/wr this cycle belong to the
                    // new state and are ignored.
                    cnt_d = '0;
                    if (cnt_q == CNT_MAX) begin
                        state_d = S_READY;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
                S_READY: begin
                    if (rd && wr) begin
                        err_d = 1'b1;
                    end else if (rd) begin
                        rd_hit = in_range;
                        dout_f = !in_range;
                        addr_d = addr_q + AW'(1);
                    end else if (wr) begin
                        we     = in_range;
                        addr_d = addr_q + AW'(1);
                    end
                end
                default: begin
                    if (rd || wr) begin
                        dout_f = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (rd_hit) begin
                dout_q <= mem[idx];
            end else if (dout_f) begin
                dout_q <= 4'hF;
            end
        end
    end

    // RAM contents survive reset. The write enable is derived from state_q,
    // which reset holds at IDLE, so no write happens while RST is low.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= nib;
        end
    end

    assign data_out = dout_q;
    assign addr     = addr_q;
    assign ready    = (state_q == S_READY);
    assign err      = err_q;

endmodule

// File: tb/tb_tholin_5401_nibble_responder.sv
// ----------------------------------------------------------------------------
// Testbench for tholin_5401_nibble_responder. Directed protocol scenarios are
// followed by randomized address/read/write phases. Everything is checked
// against a transaction-level reference model that keeps the address phase,
// the RAM and the sticky error flag as plain variables.
// ----------------------------------------------------------------------------
module tb_tholin_5401_nibble_responder;

    logic        CLK;
    logic        RST;
    logic [7:0]  bus_in;
    logic [3:0]  data_out;
    logic [11:0] addr;
    logic        ready;
    logic        err;

    tholin_5401_nibble_responder #(
        .MEM_DEPTH   (256),
        .ADDR_NIBBLES(3)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus_in  (bus_in),
        .data_out(data_out),
        .addr    (addr),
        .ready   (ready),
        .err     (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;

    // reference model
    int       m_addr;
    int       m_alecnt;
    bit       m_inaddr;
    bit       m_ready;
    bit       m_err;
    bit [3:0] m_dout;
    bit       m_dknown;
    bit [3:0] m_mem [256];
    bit       m_valid [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr   = 0;
        m_alecnt = 0;
        m_inaddr = 0;
        m_ready  = 0;
        m_err    = 0;
        m_dout   = 4'h0;
        m_dknown = 1;
    endtask

    task automatic model_step(input bit a, input bit r, input bit w, input bit [3:0] n);
        if (a) begin
            m_addr   = ((m_addr << 4) | n) % 4096;
            m_alecnt = (m_alecnt < 3) ? m_alecnt + 1 : 3;
            m_inaddr = 1;
            m_ready  = 0;
        end else if (m_inaddr) begin
            m_inaddr = 0;
            m_ready  = (m_alecnt == 3);
            if (m_alecnt != 3) m_err = 1;
            m_alecnt = 0;
        end else if (m_ready) begin
            if (r && w) begin
                m_err = 1;
            end else if (r) begin
                if (m_addr < 256) begin
                    m_dout   = m_mem[m_addr];
                    m_dknown = m_valid[m_addr];
                end else begin
                    m_dout   = 4'hF;
                    m_dknown = 1;
                end
                m_addr = (m_addr + 1) % 4096;
            end else if (w) begin
                if (m_addr < 256) begin
                    m_mem[m_addr]   = n;
                    m_valid[m_addr] = 1;
                end
                m_addr = (m_addr + 1) % 4096;
            end
        end else if (r || w) begin
            m_dout   = 4'hF;
            m_dknown = 1;
            m_err    = 1;
        end
    endtask

    task automatic check_all();
        chk("addr", 32'(addr), 32'(m_addr));
        chk("ready", 32'(ready), 32'(m_ready));
        chk("err", 32'(err), 32'(m_err));
        if (m_dknown) chk("data_out", 32'(data_out), 32'(m_dout));
    endtask

    // One bus cycle: drive at negedge, step the model on the edge,
    // compare outputs at the following negedge.
    task automatic cyc(input bit a, input bit r, input bit w, input bit [3:0] n);
        bit b7;
        b7     = 1'($urandom_range(0, 1));
        bus_in = {b7, w, r, a, n};
        @(posedge CLK);
        model_step(a, r, w, n);
        @(negedge CLK);
        check_all();
    endtask

    task automatic set_addr(input bit [11:0] a);
        cyc(1, 0, 0, a[11:8]);
        cyc(1, 0, 0, a[7:4]);
        cyc(1, 0, 0, a[3:0]);
        cyc(0, 0, 0, 4'h0);
    endtask

    task automatic do_reset();
        RST    = 1'b0;
        bus_in = 8'h00;
        #1;
        model_reset();
        check_all();
        chk("rst_data_out", 32'(data_out), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic rand_phase();
        int n, sel, k, op;
        bit [11:0] a;
        bit [3:0]  nb;
        n   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 4);
        sel = $urandom_range(0, 3);
        case (sel)
            0:       a = {4'h0, 8'($urandom)};
            1:       a = 12'h0FC + 12'($urandom_range(0, 3));
            2:       a = 12'hFFC + 12'($urandom_range(0, 3));
            default: a = 12'($urandom);
        endcase
        for (int i = 0; i < n; i++) begin
            if (i >= n - 3) nb = a[4*(n-1-i) +: 4];
            else            nb = 4'($urandom_range(0, 15));
            cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nb);
        end
        cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        k = $urandom_range(1, 12);
        for (int j = 0; j < k; j++) begin
            op = $urandom_range(0, 19);
            nb = 4'($urandom_range(0, 15));
            if (op < 8)       cyc(0, 1, 0, nb);
            else if (op < 16) cyc(0, 0, 1, nb);
            else if (op == 16) cyc(0, 1, 1, nb);
            else              cyc(0, 0, 0, nb);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_mem[i]   = 4'h0;
            m_valid[i] = 0;
        end
        RST    = 1'b0;
        bus_in = 8'h00;
        model_reset();

        // reset, then stray read in IDLE
        do_reset();
        cyc(0, 1, 0, 4'h0);
        chk("idle_rd_dout", 32'(data_out), 32'hF);
        chk("idle_rd_err", 32'(err), 32'h1);

        // address + burst write/read
        do_reset();
        set_addr(12'h012);
        chk("addr_012", 32'(addr), 32'h012);
        chk("ready_012", 32'(ready), 32'h1);
        cyc(0, 0, 1, 4'h5);
        cyc(0, 0, 1, 4'hA);
        cyc(0, 0, 1, 4'h3);
        chk("addr_after_wr", 32'(addr), 32'h015);
        set_addr(12'h012);
        cyc(0, 1, 0, 4'h0);
        chk("burst_rd0", 32'(data_out), 32'h5);
        cyc(0, 1, 0, 4'h0);
        chk("burst_rd1", 32'(data_out), 32'hA);
        cyc(0, 1, 0, 4'h0);
        chk("burst_rd2", 32'(data_out), 32'h3);

        // short address
        cyc(1, 0, 0, 4'h1);
        cyc(1, 0, 0, 4'h2);
        cyc(0, 0, 0, 4'h0);
        chk("short_ready", 32'(ready), 32'h0);
        chk("short_err", 32'(err), 32'h1);

        // overlong address: last three nibbles win
        do_reset();
        cyc(1, 0, 0, 4'h7);
        cyc(1, 0, 0, 4'h0);
        cyc(1, 1, 1, 4'h0);
        cyc(1, 0, 0, 4'h4);
        cyc(0, 0, 0, 4'h0);
        chk("long_addr", 32'(addr), 32'h004);
        chk("long_ready", 32'(ready), 32'h1);
        chk("long_err", 32'(err), 32'h0);

        // range boundary and wrap
        set_addr(12'h0FF);
        cyc(0, 0, 1, 4'h9);
        chk("wrap_0ff", 32'(addr), 32'h100);
        set_addr(12'h0FF);
        cyc(0, 1, 0, 4'h0);
        chk("rd_0ff", 32'(data_out), 32'h9);
        cyc(0, 1, 0, 4'h0);
        chk("rd_100", 32'(data_out), 32'hF);
        chk("rd_100_err", 32'(err), 32'h0);
        set_addr(12'hFFF);
        cyc(0, 1, 0, 4'h0);
        chk("wrap_fff", 32'(addr), 32'h000);
        cyc(0, 1, 1, 4'h6);
        chk("rdwr_addr", 32'(addr), 32'h000);
        chk("rdwr_err", 32'(err), 32'h1);

        // async reset in the middle of a read burst
        set_addr(12'h012);
        cyc(0, 1, 0, 4'h0);
        bus_in = 8'h20;
        @(posedge CLK);
        model_step(0, 1, 0, 4'h0);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_dout", 32'(data_out), 32'h0);
        chk("async_ready", 32'(ready), 32'h0);
        @(negedge CLK);
        RST    = 1'b1;
        bus_in = 8'h00;
        set_addr(12'h012);
        cyc(0, 1, 0, 4'h0);
        chk("keep_rd0", 32'(data_out), 32'h5);
        cyc(0, 1, 0, 4'h0);
        chk("keep_rd1", 32'(data_out), 32'hA);

        // randomized traffic
        for (int p = 0; p < 300; p++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            rand_phase();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
